// File: rtl/lsu_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared state encoding and RV32 funct3 constants for the LSU.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD     = 3'd1,
    ST     = 3'd2,
    RMW_RD = 3'd3,
    RMW_WR = 3'd4,
    RESP   = 3'd5
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only have the signed encodings; loads add the unsigned variants.
  function automatic logic f3_legal(input logic store, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!store) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_ctrl_if
//  Description : Core request/response and data-memory bus for the LSU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_write_enable, mem_read_enable, mem_address, mem_data_in
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_write_enable, mem_read_enable, mem_address, mem_data_in
  );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_ctrl_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane_align
//  Description : Load lane extraction/extension and sub-word store merge.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_load_word,
  input  logic [31:0] i_old_word,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_load_word[7:0];
      2'd1:    w_byte = i_load_word[15:8];
      2'd2:    w_byte = i_load_word[23:16];
      default: w_byte = i_load_word[31:24];
    endcase
    w_half = i_lane[1] ? i_load_word[31:16] : i_load_word[15:0];

    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load_data = {24'd0, w_byte};
      F3_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = i_load_word;
    endcase

    o_merged = i_old_word;
    case (i_funct3)
      F3_B: begin
        case (i_lane)
          2'd0:    o_merged[7:0]   = i_wdata[7:0];
          2'd1:    o_merged[15:8]  = i_wdata[7:0];
          2'd2:    o_merged[23:16] = i_wdata[7:0];
          default: o_merged[31:24] = i_wdata[7:0];
        endcase
      end
      F3_H: begin
        if (i_lane[1]) o_merged[31:16] = i_wdata;
        else           o_merged[15:0]  = i_wdata;
      end
      default: o_merged = i_old_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_ctrl
//  Description : Single-outstanding RV32 load/store initiator with RMW stores.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic           clk,
  input  logic           rst,
  lsu_mem_ctrl_if.slave  bus
);

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_funct3;
  logic [AW-1:0]   r_idx;
  logic [1:0]      r_lane;
  logic [31:0]     r_wdata;
  logic [31:0]     r_old;
  logic [31:0]     r_rdata;
  logic            r_resp_err;

  logic            w_accept;
  logic            w_misalign;
  logic            w_range_err;
  logic            w_req_err;
  logic            w_set_resp;
  logic [31:0]     w_load_data;
  logic [31:0]     w_merged;

  assign w_accept    = bus.req_valid && (r_state == IDLE);
  // funct3[1:0] is 01 for both half encodings and 10 for word.
  assign w_misalign  = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign w_range_err = ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_req_err   = !f3_legal(bus.req_store, bus.req_funct3) || w_misalign || w_range_err;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_req_err)                 w_next = RESP;
          else if (!bus.req_store)       w_next = LD;
          else if (bus.req_funct3 == F3_W) w_next = ST;
          else                           w_next = RMW_RD;
        end
      end
      LD:      w_next = RESP;
      ST:      w_next = RESP;
      RMW_RD:  w_next = RMW_WR;
      RMW_WR:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_set_resp = (w_next == RESP) && (r_state != RESP);

  lsu_lane_align u_align (
    .i_funct3    (r_funct3),
    .i_lane      (r_lane),
    .i_load_word (bus.mem_data_out),
    .i_old_word  (r_old),
    .i_wdata     (r_wdata[15:0]),
    .o_load_data (w_load_data),
    .o_merged    (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_funct3   <= 3'd0;
      r_idx      <= '0;
      r_lane     <= 2'd0;
      r_wdata    <= 32'd0;
      r_old      <= 32'd0;
      r_rdata    <= 32'd0;
      r_resp_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_funct3 <= bus.req_funct3;
        r_idx    <= bus.req_addr[AW+1:2];
        r_lane   <= bus.req_addr[1:0];
        r_wdata  <= bus.req_wdata;
      end
      if (r_state == RMW_RD) r_old <= bus.mem_data_out;
      // Response fields stay put until the next response is formed.
      if (w_set_resp) begin
        r_rdata    <= (r_state == LD) ? w_load_data : 32'd0;
        r_resp_err <= (r_state == IDLE);
      end
    end
  end

  always_comb begin
    bus.mem_data_in = 32'd0;
    case (r_state)
      ST:      bus.mem_data_in = r_wdata;
      RMW_WR:  bus.mem_data_in = w_merged;
      default: bus.mem_data_in = 32'd0;
    endcase
  end

  assign bus.req_ready        = (r_state == IDLE);
  assign bus.resp_valid       = (r_state == RESP);
  assign bus.resp_rdata       = r_rdata;
  assign bus.resp_err         = r_resp_err;
  assign bus.mem_read_enable  = (r_state == LD) || (r_state == RMW_RD);
  assign bus.mem_write_enable = ((r_state == ST) || (r_state == RMW_WR)) && !rst;
  assign bus.mem_address      = {{(32-AW){1'b0}}, r_idx};

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_mem_ctrl
//  Description : Directed self-checking bench for lsu_mem_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic clk;
  logic rst;
  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.DEPTH_WORDS(256), .AW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: writes on posedge, reads sampled on negedge.
  logic [31:0] mem [0:255];
  always @(posedge clk) if (bus.mem_write_enable) mem[bus.mem_address[7:0]] <= bus.mem_data_in;
  always @(negedge clk) if (bus.mem_read_enable) bus.mem_data_out <= mem[bus.mem_address[7:0]];

  int overlap_cnt = 0;
  always @(negedge clk) if (bus.mem_read_enable && bus.mem_write_enable) overlap_cnt++;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // One request; reports response latency (0 = none within budget), data and enable counts.
  task automatic xact(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic er,
                      output int nrd, output int nwr);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; rd = 32'hx; er = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.mem_read_enable)  nrd++;
      if (bus.mem_write_enable) nwr++;
      if (bus.resp_valid) begin
        lat = i; rd = bus.resp_rdata; er = bus.resp_err;
        break;
      end
    end
  endtask

  int          lat, nrd, nwr, busy_lo, idx, nresp;
  logic [31:0] rd;
  logic        er;
  logic [31:0] got [0:2];
  logic        acc;

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we",   32'(bus.mem_write_enable), 32'd0);
    check("rst_re",   32'(bus.mem_read_enable),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready",  32'(bus.req_ready),  32'd1);
    check("rst_rvalid", 32'(bus.resp_valid), 32'd0);
    check("rst_err",    32'(bus.resp_err),   32'd0);
    check("rst_rdata",  bus.resp_rdata,      32'd0);
    check("rst_addr",   bus.mem_address,     32'd0);
    check("rst_din",    bus.mem_data_in,     32'd0);

    // SW then LW on word 4
    xact(1'b1, F3_W, 32'h10, 32'hDEADBEEF, lat, rd, er, nrd, nwr);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_nwr", 32'(nwr), 32'd1);
    check("sw_nrd", 32'(nrd), 32'd0);
    check("sw_err", 32'(er),  32'd0);
    check("sw_mem", mem[4],   32'hDEADBEEF);
    xact(1'b0, F3_W, 32'h10, 32'd0, lat, rd, er, nrd, nwr);
    check("lw_lat",   32'(lat), 32'd2);
    check("lw_rdata", rd,       32'hDEADBEEF);
    check("lw_err",   32'(er),  32'd0);
    @(negedge clk);
    check("lw_hold",  bus.resp_rdata, 32'hDEADBEEF);
    check("lw_idle_ready", 32'(bus.req_ready), 32'd1);

    // SB read-modify-write
    xact(1'b1, F3_W, 32'h10, 32'h11223344, lat, rd, er, nrd, nwr);
    xact(1'b1, F3_B, 32'h12, 32'h000000AA, lat, rd, er, nrd, nwr);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_nrd", 32'(nrd), 32'd1);
    check("sb_nwr", 32'(nwr), 32'd1);
    check("sb_mem", mem[4],   32'h11AA3344);

    // Extension variants
    xact(1'b1, F3_W, 32'h10, 32'h8000F0FF, lat, rd, er, nrd, nwr);
    xact(1'b0, F3_B,  32'h10, 32'd0, lat, rd, er, nrd, nwr); check("lb",   rd, 32'hFFFFFFFF);
    xact(1'b0, F3_BU, 32'h10, 32'd0, lat, rd, er, nrd, nwr); check("lbu",  rd, 32'h000000FF);
    xact(1'b0, F3_H,  32'h12, 32'd0, lat, rd, er, nrd, nwr); check("lh",   rd, 32'hFFFF8000);
    xact(1'b0, F3_HU, 32'h12, 32'd0, lat, rd, er, nrd, nwr); check("lhu",  rd, 32'h00008000);
    xact(1'b0, F3_B,  32'h13, 32'd0, lat, rd, er, nrd, nwr); check("lb3",  rd, 32'hFFFFFF80);
    xact(1'b1, F3_H,  32'h10, 32'h1234CAFE, lat, rd, er, nrd, nwr);
    check("sh_lat", 32'(lat), 32'd3);
    check("sh_mem", mem[4],   32'h8000CAFE);

    // Error requests
    xact(1'b0, F3_W, 32'h13, 32'd0, lat, rd, er, nrd, nwr);
    check("e_lw13_lat", 32'(lat), 32'd1); check("e_lw13_err", 32'(er), 32'd1);
    check("e_lw13_rd", rd, 32'd0);        check("e_lw13_en", 32'(nrd + nwr), 32'd0);
    xact(1'b1, F3_H, 32'h11, 32'hFFFF, lat, rd, er, nrd, nwr);
    check("e_sh11_lat", 32'(lat), 32'd1); check("e_sh11_err", 32'(er), 32'd1);
    check("e_sh11_rd", rd, 32'd0);        check("e_sh11_en", 32'(nrd + nwr), 32'd0);
    check("e_sh11_mem", mem[4], 32'h8000CAFE);
    xact(1'b0, F3_W, 32'h400, 32'd0, lat, rd, er, nrd, nwr);
    check("e_oor_lat", 32'(lat), 32'd1);  check("e_oor_err", 32'(er), 32'd1);
    check("e_oor_rd", rd, 32'd0);         check("e_oor_en", 32'(nrd + nwr), 32'd0);
    xact(1'b0, 3'b011, 32'h10, 32'd0, lat, rd, er, nrd, nwr);
    check("e_f3_lat", 32'(lat), 32'd1);   check("e_f3_err", 32'(er), 32'd1);
    check("e_f3_rd", rd, 32'd0);          check("e_f3_en", 32'(nrd + nwr), 32'd0);
    xact(1'b1, F3_BU, 32'h10, 32'd0, lat, rd, er, nrd, nwr);
    check("e_sbu_err", 32'(er), 32'd1);

    // Reset during RMW_WR of SH 0x20
    xact(1'b1, F3_W, 32'h20, 32'h55667788, lat, rd, er, nrd, nwr);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = F3_H;
    bus.req_addr = 32'h20; bus.req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rr_rd_phase", 32'(bus.mem_read_enable), 32'd1);
    @(negedge clk);
    check("rr_wr_phase", 32'(bus.mem_write_enable), 32'd1);
    rst = 1'b1;
    #1 check("rr_we_gated", 32'(bus.mem_write_enable), 32'd0);
    @(negedge clk);
    check("rr_no_resp0", 32'(bus.resp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rr_ready",    32'(bus.req_ready),  32'd1);
    check("rr_no_resp1", 32'(bus.resp_valid), 32'd0);
    check("rr_mem",      mem[8],              32'h55667788);
    xact(1'b0, F3_W, 32'h20, 32'd0, lat, rd, er, nrd, nwr);
    check("rr_lw", rd, 32'h55667788);

    // Back-to-back loads with req_valid held
    xact(1'b1, F3_W, 32'h30, 32'h0A0A0A01, lat, rd, er, nrd, nwr);
    xact(1'b1, F3_W, 32'h34, 32'h0B0B0B02, lat, rd, er, nrd, nwr);
    xact(1'b1, F3_W, 32'h38, 32'h0C0C0C03, lat, rd, er, nrd, nwr);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = F3_W; bus.req_addr = 32'h30;
    idx = 0; nresp = 0; busy_lo = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.resp_valid && nresp < 3) begin got[nresp] = bus.resp_rdata; nresp++; end
      if (!bus.req_ready) busy_lo++;
      if (nresp == 3) break;
      acc = bus.req_valid && bus.req_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx == 3) bus.req_valid = 1'b0;
        else          bus.req_addr = 32'h30 + 32'(4 * idx);
      end
      @(negedge clk);
    end
    check("b2b_nresp",  32'(nresp),   32'd3);
    check("b2b_accept", 32'(idx),     32'd3);
    check("b2b_busy",   32'(busy_lo), 32'd6);
    check("b2b_r0", got[0], 32'h0A0A0A01);
    check("b2b_r1", got[1], 32'h0B0B0B02);
    check("b2b_r2", got[2], 32'h0C0C0C03);

    check("no_overlap", 32'(overlap_cnt), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
